// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - single-outstanding data memory responder with fixed response latency
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 256,
    parameter int LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy
);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int NBYTES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(4 * DEPTH);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state;
    state_t state_nxt;
    logic [3:0] lat_cnt;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
    logic [IDX_W-1:0] idx_q;
    logic we_q;
    logic err_q;
    logic accept;
    logic entering_resp;
    logic req_err;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] rd_idx;
    logic rd_err;
    logic rd_null;

    assign req_idx = req_addr[IDX_W+1:2];
    assign req_err = (req_addr[1:0] != 2'b00) || ({1'b0, req_addr} >= ADDR_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == 4'd1) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the response is built on the accepting edge, so the live request is used.
    assign entering_resp = (state != RESP) && (state_nxt == RESP);
    assign rd_idx  = (state == IDLE) ? req_idx : idx_q;
    assign rd_err  = (state == IDLE) ? req_err : err_q;
    assign rd_null = (state == IDLE) ? (req_we || req_err) : (we_q || err_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_cnt   <= 4'd0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem       <= '0;
        end else begin
            if (accept) begin
                lat_cnt <= LAT_LOAD;
                idx_q   <= req_idx;
                we_q    <= req_we;
                err_q   <= req_err;
                if (req_we && !req_err) begin
                    for (int b = 0; b < NBYTES; b++) begin
                        if (req_wstrb[b]) begin
                            mem[req_idx][b*8 +: 8] <= req_wdata[b*8 +: 8];
                        end
                    end
                end
            end else if (state == WAIT) begin
                lat_cnt <= lat_cnt - 4'd1;
            end

            if (entering_resp) begin
                rsp_rdata <= rd_null ? '0 : mem[rd_idx];
                rsp_err   <= rd_err;
            end else if (state == RESP && rsp_ready) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed vector bench for dmem_responder (LATENCY 2 and LATENCY 1 builds)
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_wstrb;
    logic        a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
    logic [31:0] a_rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_wstrb;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [31:0] b_rsp_rdata;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_wstrb(a_req_wstrb),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .busy(a_busy)
    );

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic run_a(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        @(negedge clk);
        check({tag, " req_ready"}, 32'(a_req_ready), 32'd1);
        a_req_valid = 1'b1;
        a_req_we    = we;
        a_req_addr  = addr;
        a_req_wdata = wdata;
        a_req_wstrb = wstrb;
        @(negedge clk);
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd2);
        check({tag, " rdata"}, a_rsp_rdata, exp_rdata);
        check({tag, " err"}, 32'(a_rsp_err), 32'(exp_err));
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
        check({tag, " valid after consume"}, 32'(a_rsp_valid), 32'd0);
        check({tag, " rdata/err cleared"}, {a_rsp_rdata[30:0], a_rsp_err}, 32'd0);
    endtask

    initial begin
        int lat;
        int rises;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 32'h0000_03FC, 32'h5566_7788, 4'hF, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0003, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0400, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
        vecs[8]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0002, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h1122_3344, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'h5566_7788, 1'b0};
        vecs[12] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h0, 32'h0000_0000, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
        vecs[14] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'hC, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h1234_BEAA, 1'b0};
        vecs[16] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        vecs[17] = '{1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'h0000_0000, 1'b1};

        reset = 1'b1;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_wstrb = '0;
        a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
        b_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset req_ready", 32'(a_req_ready), 32'd1);
        check("reset rsp_valid", 32'(a_rsp_valid), 32'd0);
        check("reset rsp_rdata", a_rsp_rdata, 32'd0);
        check("reset rsp_err", 32'(a_rsp_err), 32'd0);
        check("reset busy", 32'(a_busy), 32'd0);

        for (int i = 0; i < 18; i++) begin
            run_a($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                  vecs[i].wstrb, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Backpressure: response held 5 cycles while a competing write is offered.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h0;
        @(negedge clk);
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("hold latency", 32'(lat), 32'd2);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h0;
        a_req_wdata = 32'hFFFF_FFFF; a_req_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("hold%0d rsp_valid", i), 32'(a_rsp_valid), 32'd1);
            check($sformatf("hold%0d rdata", i), a_rsp_rdata, 32'h1122_3344);
            check($sformatf("hold%0d req_ready", i), 32'(a_req_ready), 32'd0);
            check($sformatf("hold%0d busy", i), 32'(a_busy), 32'd1);
            @(negedge clk);
        end
        a_req_valid = 1'b0; a_req_we = 1'b0;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
        run_a("after hold", 1'b0, 32'h0, 32'h0, 4'h0, 32'h1122_3344, 1'b0);

        // Reset during WAIT aborts the write and clears memory.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h40;
        a_req_wdata = 32'hAAAA_AAAA; a_req_wstrb = 4'hF;
        @(negedge clk);
        a_req_valid = 1'b0;
        check("abort in wait busy", 32'(a_busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 32'(a_busy), 32'd0);
        check("abort req_ready", 32'(a_req_ready), 32'd1);
        rises = 0;
        for (int i = 0; i < 4; i++) begin
            if (a_rsp_valid) rises++;
            @(negedge clk);
        end
        check("abort no response", 32'(rises), 32'd0);
        run_a("abort read 0x40", 1'b0, 32'h40, 32'h0, 4'h0, 32'h0, 1'b0);
        run_a("abort read 0x10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

        // Reset during RESP drops the pending response.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'h3FC;
        @(negedge clk);
        a_req_valid = 1'b0;
        @(negedge clk);
        check("resp abort valid before", 32'(a_rsp_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("resp abort valid after", 32'(a_rsp_valid), 32'd0);
        check("resp abort err", 32'(a_rsp_err), 32'd0);

        // LATENCY=1 build: rsp_ready tied high, request held continuously.
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h8;
        b_req_wdata = 32'h0BAD_F00D; b_req_wstrb = 4'hF;
        @(negedge clk);
        check("L1 write rsp_valid", 32'(b_rsp_valid), 32'd1);
        check("L1 write rdata", b_rsp_rdata, 32'd0);
        b_req_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("L1 rd%0d idle req_ready", i), 32'(b_req_ready), 32'd1);
            check($sformatf("L1 rd%0d idle rsp_valid", i), 32'(b_rsp_valid), 32'd0);
            @(negedge clk);
            check($sformatf("L1 rd%0d rsp_valid", i), 32'(b_rsp_valid), 32'd1);
            check($sformatf("L1 rd%0d rdata", i), b_rsp_rdata, 32'h0BAD_F00D);
            check($sformatf("L1 rd%0d req_ready", i), 32'(b_req_ready), 32'd0);
        end
        b_req_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 Parameter DEPTH, default 256, number of DATA_WIDTH words stored.
REQ-004 Parameter LATENCY, default 2, cycles from request acceptance to rsp_valid; legal range 1..15.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req_valid  input  1  initiator presents a request.
REQ-008 req_ready  output  1  responder accepts a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_WIDTH  byte address.
REQ-011 req_wdata  input  DATA_WIDTH  write data.
REQ-012 req_wstrb  input  DATA_WIDTH/8  byte-lane write enables.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  initiator consumes the response.
REQ-015 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-016 rsp_err  output  1  request was misaligned or out of range.
REQ-017 busy  output  1  high whenever state is not IDLE; stall source for the pipeline hazard logic.

Function
REQ-018 FSM states IDLE, WAIT, RESP; req_ready = (state == IDLE); rsp_valid = (state == RESP).
REQ-019 Acceptance: req_valid & req_ready at a rising edge captures req_we, req_addr, req_wdata, req_wstrb and the error flag; request inputs are ignored in WAIT and RESP.
REQ-020 Word index = req_addr[log2(DEPTH)+1:2].
REQ-021 Error when req_addr[1:0] != 0 or req_addr >= 4*DEPTH; error requests perform no write and return rsp_rdata = 0, rsp_err = 1.
REQ-022 Valid write: each byte lane i with req_wstrb[i] = 1 is written at the accepting edge; other lanes keep their value; req_wstrb = 0 writes nothing and is not an error.
REQ-023 IDLE -> WAIT on acceptance with a 4-bit latency counter loaded to LATENCY-1; when LATENCY = 1, IDLE -> RESP directly.
REQ-024 WAIT: counter decrements each cycle; WAIT -> RESP on the edge where the counter equals 1; rsp_valid is first high exactly LATENCY cycles after the accepting edge.
REQ-025 Read data is sampled from storage on the edge entering RESP and registered into rsp_rdata; a read immediately following a write to the same word returns the written data.
REQ-026 RESP: rsp_valid, rsp_rdata and rsp_err stay stable until rsp_ready = 1; RESP -> IDLE on that edge; rsp_ready while rsp_valid = 0 is ignored.
REQ-027 Throughput: at most one outstanding request; minimum spacing between acceptances is LATENCY+1 cycles.
REQ-028 rsp_rdata and rsp_err return to 0 on the RESP -> IDLE edge.

Reset
REQ-029 reset = 1 at a rising edge forces state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, busy 0, and clears all DEPTH words to 0.
REQ-030 reset asserted during WAIT or RESP aborts the transaction; no response is issued for it; a write already committed at acceptance is also cleared by the reset.
REQ-031 Reset has priority over acceptance and rsp_ready in the same cycle; req_ready is 1 on the first cycle after reset deasserts.

Verification
REQ-032 Write addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then read 0x10 -> write response rsp_rdata 0, rsp_err 0; read response rsp_rdata 0xDEADBEEF, rsp_valid high exactly 2 cycles after each acceptance.
REQ-033 Word 0x10 holds 0xDEADBEEF; write 0x10 with 0x000000AA, wstrb 0x1; read -> 0xDEADBEAA.
REQ-034 Read addr 0x3 and read addr 0x400 (DEPTH 256) -> rsp_err 1, rsp_rdata 0; contents of words 0 and 255 unchanged.
REQ-035 Read with rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stable for all 5 cycles; req_ready 0 throughout; req_valid pulses in that window not accepted.
REQ-036 Write accepted, reset asserted in the next cycle (WAIT) -> rsp_valid never rises; a later read of that word returns 0; busy 0 the cycle after reset.
REQ-037 LATENCY = 1 build, back-to-back reads with rsp_ready tied 1 -> accept every 2nd cycle, rsp_valid one cycle after each acceptance.
